bin2bcd_arb: RTL
================

BIN2BCD_ARB -- requirements
Module: bin2bcd_arb

Interface
REQ-001 SHALL have parameters: NREQ, default 4, number of requesters; LAT, default 4, fixed latency of the shared bin2bcd_pipeline in cycles; DEPTH, default 8, tag FIFO depth, which SHALL be at least LAT+1.
REQ-002 SHALL have ports:
- clk  input  1  sole clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NREQ  per-requester conversion request, held until granted.
- req_bin  input  11*NREQ  signed 11-bit operand per requester; slice i is bits [11i+10:11i].
- gnt  output  NREQ  one-hot grant; combinational; transfer occurs when req[i]&gnt[i] at a rising edge.
- cv_bin  output  11  operand driven to the shared converter.
- cv_bin_vld  output  1  operand valid to the shared converter.
- cv_bcd  input  17  converter result: sign plus 4 BCD digits.
- cv_bcd_vld  input  1  converter result valid.
- rsp_vld  output  NREQ  one-hot result-valid, routed to the originating requester.
- rsp_bcd  output  17  result data, shared by all requesters.
- err  output  1  sticky protocol error flag.

Function
REQ-003 gnt SHALL be all-zero when req is zero, or when the tag FIFO count equals DEPTH.
REQ-004 gnt SHALL never have more than one bit set.
REQ-005 A transfer in cycle T SHALL drive cv_bin equal to the granted req_bin slice, with cv_bin_vld=1, in cycle T+1.
REQ-006 cv_bin_vld SHALL be 0 in any cycle that follows a cycle with no transfer.
- cv_bin SHALL hold its last value when cv_bin_vld is 0.
REQ-007 Each transfer SHALL push the granted requester index (log2 NREQ bits) into an in-order tag FIFO.
REQ-008 Each cv_bcd_vld=1 SHALL pop the FIFO head tag h and, in the next cycle, drive rsp_bcd=cv_bcd and rsp_vld=one-hot(h).
- Otherwise rsp_vld SHALL be 0 and rsp_bcd SHALL hold its last value.
REQ-009 A push and a pop in the same cycle SHALL leave the count unchanged.
- A full FIFO SHALL NOT grant in that cycle; there is no same-cycle bypass.
REQ-010 cv_bcd_vld=1 with an empty FIFO SHALL set err=1.
- It SHALL NOT pop, SHALL NOT drive rsp_vld, and err SHALL remain 1 until rst.
REQ-011 Total latency from a transfer at edge T to rsp_vld SHALL be LAT+2 cycles, given a converter of latency LAT.
REQ-012 Back-to-back transfers SHALL be accepted every cycle while the FIFO is not full.
- Sustained throughput SHALL be one conversion per cycle.
REQ-013 Arbitration is round-robin when BCD_ARB_RR_EN is defined (see REQ-018).
- The pointer SHALL advance to (granted index + 1) mod NREQ after each transfer.
- The pointer SHALL be unchanged when no transfer occurs.
REQ-014 Operand values SHALL pass through unmodified.
- The full signed range -1024..1023 is forwarded without checking.

Reset
REQ-015 While rst=1, the block SHALL drive, in the cycle after the edge, gnt=0, cv_bin=0, cv_bin_vld=0, rsp_vld=0, rsp_bcd=0 and err=0.
- It SHALL also empty the FIFO (count 0) and set the round-robin pointer to 0.
REQ-016 For LAT cycles after rst deasserts, cv_bcd_vld pulses SHALL be discarded silently.
- This covers stale in-flight results: no rsp_vld and no err.
- gnt SHALL remain 0 during this drain window.
REQ-017 rst asserted mid-operation SHALL abandon all outstanding tags; no rsp_vld SHALL be produced for them.

Configuration
REQ-018 Macro BCD_ARB_RR_EN SHALL select the arbitration policy.
- Defined: round-robin per REQ-013.
- Undefined: fixed priority, lowest index wins; no pointer register is built.

Verification
REQ-019 The bench SHALL model the converter as an LAT=4 delay line performing the real bin2bcd conversion, and SHALL cover:
- Single request: req=0001, req_bin[0]=-1023 -> gnt=0001 for one transfer; cv_bin=-1023 next cycle; rsp_vld=0001 with rsp_bcd=sign 1, digits 1023, six cycles after the transfer.
- All four requesting continuously, RR enabled, operands 5, 67, 890, 1023 -> grants 0,1,2,3,0,... one per cycle; each requester receives its own BCD in order.
- Same stimulus with BCD_ARB_RR_EN undefined, requester 0 never dropping req -> only requester 0 is granted.
- Converter stalled (cv_bcd_vld held 0) with continuous requests -> exactly 8 transfers, then gnt=0; the first cv_bcd_vld resumes one grant per pop.
- Spurious cv_bcd_vld after the drain window with an empty FIFO -> err=1 and sticky; rsp_vld stays 0; rst clears err.
- rst asserted with 3 requests in flight -> no rsp_vld for them, even as the delay line emits them; err stays 0.

Source files
------------

// File: rtl/bin2bcd_arb.sv
// bin2bcd_arb: shares one fixed-latency bin2bcd pipeline among NREQ requesters.
// Grants one operand per cycle, forwards it to the converter, and remembers
// the requester index in an in-order tag FIFO so each converter result can
// be routed back to the requester that issued it.
// Build option: define BCD_ARB_RR_EN for round-robin arbitration; when it is
// undefined the arbiter is fixed priority (lowest index wins).
//
// Handshake: a transfer happens when req[i] & gnt[i] are both high at a
// rising edge; gnt is combinational from req and internal state, and a
// requester holds req until it sees its grant at an edge.
module bin2bcd_arb #(
   parameter int NREQ  = 4,
   parameter int LAT   = 4,
   parameter int DEPTH = 8   // must be at least LAT+1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [11*NREQ-1:0]   req_bin,
   output logic [NREQ-1:0]      gnt,
   output logic [10:0]          cv_bin,
   output logic                 cv_bin_vld,
   input  logic [16:0]          cv_bcd,
   input  logic                 cv_bcd_vld,
   output logic [NREQ-1:0]      rsp_vld,
   output logic [16:0]          rsp_bcd,
   output logic                 err
);

   localparam int TW = (NREQ > 1)  ? $clog2(NREQ)    : 1;
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH)   : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int DW = (LAT > 0)   ? $clog2(LAT + 1) : 1;

   logic [CW-1:0]   cnt_q, cnt_d;
   logic [PW-1:0]   wr_q, wr_d;
   logic [PW-1:0]   rd_q, rd_d;
   logic [TW-1:0]   fifo_q [DEPTH];
   logic [TW-1:0]   fifo_d [DEPTH];
   logic [DW-1:0]   drain_q, drain_d;
   logic [10:0]     cv_bin_q, cv_bin_d;
   logic            cv_bin_vld_q, cv_bin_vld_d;
   logic [NREQ-1:0] rsp_vld_q, rsp_vld_d;
   logic [16:0]     rsp_bcd_q, rsp_bcd_d;
   logic            err_q, err_d;

   logic            gnt_any;
   logic [TW-1:0]   gnt_idx;
   logic            can_grant;
   logic            xfer;
   logic            pop;
   logic            spurious;

`ifdef BCD_ARB_RR_EN
   logic [TW-1:0]   rr_q, rr_d;
   int              rr_k;
`endif

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Arbiter: pick one requester, then mask the grant while in reset, while
   // stale converter results drain, or while the tag FIFO is full.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
`ifdef BCD_ARB_RR_EN
      rr_k = 0;
      for (int i = 0; i < NREQ; i++) begin
         rr_k = int'(rr_q) + i;
         if (rr_k >= NREQ) rr_k = rr_k - NREQ;
         if (!gnt_any && req[rr_k]) begin
            gnt_any = 1'b1;
            gnt_idx = TW'(rr_k);
         end
      end
`else
      for (int i = 0; i < NREQ; i++) begin
         if (!gnt_any && req[i]) begin
            gnt_any = 1'b1;
            gnt_idx = TW'(i);
         end
      end
`endif
      can_grant = !rst && (drain_q == '0) && (cnt_q != CW'(DEPTH));
      gnt = '0;
      if (gnt_any && can_grant) gnt[gnt_idx] = 1'b1;
   end

   assign xfer     = |(req & gnt);
   // Results arriving during the post-reset drain window belong to abandoned
   // tags and are dropped without popping or flagging an error.
   assign pop      = cv_bcd_vld && (drain_q == '0) && (cnt_q != '0);
   assign spurious = cv_bcd_vld && (drain_q == '0) && (cnt_q == '0);

   // Next-state: operand register, tag FIFO, response routing and error flag.
   always_comb begin
      cnt_d        = cnt_q;
      wr_d         = wr_q;
      rd_d         = rd_q;
      fifo_d       = fifo_q;
      drain_d      = (drain_q != '0) ? drain_q - DW'(1) : drain_q;
      cv_bin_d     = cv_bin_q;
      cv_bin_vld_d = xfer;
      rsp_vld_d    = '0;
      rsp_bcd_d    = rsp_bcd_q;
      err_d        = err_q | spurious;
`ifdef BCD_ARB_RR_EN
      rr_d         = rr_q;
`endif
      if (xfer) begin
         cv_bin_d     = req_bin[11*int'(gnt_idx) +: 11];
         fifo_d[wr_q] = gnt_idx;
         wr_d         = ptr_inc(wr_q);
`ifdef BCD_ARB_RR_EN
         rr_d         = (gnt_idx == TW'(NREQ - 1)) ? '0 : gnt_idx + TW'(1);
`endif
      end
      if (pop) begin
         rsp_vld_d[fifo_q[rd_q]] = 1'b1;
         rsp_bcd_d               = cv_bcd;
         rd_d                    = ptr_inc(rd_q);
      end
      case ({xfer, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers; reset abandons outstanding tags and opens the drain window.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         wr_q         <= '0;
         rd_q         <= '0;
         drain_q      <= DW'(LAT);
         cv_bin_q     <= '0;
         cv_bin_vld_q <= 1'b0;
         rsp_vld_q    <= '0;
         rsp_bcd_q    <= '0;
         err_q        <= 1'b0;
`ifdef BCD_ARB_RR_EN
         rr_q         <= '0;
`endif
      end else begin
         cnt_q        <= cnt_d;
         wr_q         <= wr_d;
         rd_q         <= rd_d;
         fifo_q       <= fifo_d;
         drain_q      <= drain_d;
         cv_bin_q     <= cv_bin_d;
         cv_bin_vld_q <= cv_bin_vld_d;
         rsp_vld_q    <= rsp_vld_d;
         rsp_bcd_q    <= rsp_bcd_d;
         err_q        <= err_d;
`ifdef BCD_ARB_RR_EN
         rr_q         <= rr_d;
`endif
      end
   end

   assign cv_bin     = cv_bin_q;
   assign cv_bin_vld = cv_bin_vld_q;
   assign rsp_vld    = rsp_vld_q;
   assign rsp_bcd    = rsp_bcd_q;
   assign err        = err_q;

endmodule
